// File: rtl/mod_counter_if.sv
// Control/status bundle for one mod_counter stage.
// With MOD_COUNTER_OVF_STICKY_EN defined, the bundle also carries the sticky ovf flag.
interface mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic             one_shot;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             busy;
  logic             done;
`ifdef MOD_COUNTER_OVF_STICKY_EN
  logic             ovf;

  modport master (
    output en, start, stop, clear, load, load_val, up_dn, one_shot,
    input  count, carry, busy, done, ovf
  );
  modport slave (
    input  en, start, stop, clear, load, load_val, up_dn, one_shot,
    output count, carry, busy, done, ovf
  );
`else
  modport master (
    output en, start, stop, clear, load, load_val, up_dn, one_shot,
    input  count, carry, busy, done
  );
  modport slave (
    input  en, start, stop, clear, load, load_val, up_dn, one_shot,
    output count, carry, busy, done
  );
`endif
endinterface

// File: rtl/mod_counter.sv
// Modulo-N up/down counter stage with IDLE/RUN/DONE run control and cascade carry.
// Optional sticky overflow flag enabled by defining MOD_COUNTER_OVF_STICKY_EN.
module mod_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input logic          clk,
  input logic          rst_n,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] term_val;
  logic             carry;

  assign term_val     = bus.up_dn ? MaxCnt : '0;
  assign carry        = (state_q == StRun) && bus.en && (count_q == term_val);
  assign load_clamped = ({1'b0, bus.load_val} >= ModExt) ? MaxCnt : bus.load_val;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (bus.up_dn) begin
      step_val = (count_q == MaxCnt) ? '0 : count_q + 1'b1;
    end else begin
      step_val = (count_q == '0) ? MaxCnt : count_q - 1'b1;
    end

    // Priority: clear > load > stop > start > count.
    if (bus.clear) begin
      count_d = '0;
      state_d = StIdle;
    end else if (bus.load) begin
      count_d = load_clamped;
    end else if (bus.stop) begin
      if (state_q == StRun) begin
        state_d = StIdle;
      end
    end else if (bus.start && (state_q != StRun)) begin
      state_d = StRun;
    end else if ((state_q == StRun) && bus.en) begin
      count_d = step_val;
      if (bus.one_shot && carry) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef MOD_COUNTER_OVF_STICKY_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      ovf_q <= 1'b0;
    end else if (carry) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.count = count_q;
  assign bus.carry = carry;
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter: directed scenarios, random stimulus against a
// behavioural model, and a two-stage cascade.
module tb_mod_counter;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 10;

  logic clk;
  logic rst_n;

  mod_counter_if #(.WIDTH(W)) if1 ();
  mod_counter_if #(.WIDTH(W)) if2 ();

  mod_counter #(.WIDTH(W), .MODULUS(MOD)) u_stage1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1.slave)
  );

  mod_counter #(.WIDTH(W), .MODULUS(MOD)) u_stage2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if2.slave)
  );

  assign if2.en = if1.carry & 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of stage 1
  int m_cnt;
  bit m_busy;
  bit m_done;
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_busy = 0;
    m_done = 0;
    m_ovf  = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".count"}, 32'(if1.count), m_cnt);
    chk({tag, ".busy"}, 32'(if1.busy), 32'(m_busy));
    chk({tag, ".done"}, 32'(if1.done), 32'(m_done));
`ifdef MOD_COUNTER_OVF_STICKY_EN
    chk({tag, ".ovf"}, 32'(if1.ovf), 32'(m_ovf));
`endif
  endtask

  // One clock of stage 1: check carry before the edge, registers after it.
  task automatic step(input string tag);
    bit c;
    int tv;
    #1;
    tv = if1.up_dn ? int'(MOD) - 1 : 0;
    c  = m_busy && if1.en && (m_cnt == tv);
    chk({tag, ".carry"}, 32'(if1.carry), 32'(c));
    @(posedge clk);
    if (if1.clear) begin
      m_cnt  = 0;
      m_busy = 0;
      m_done = 0;
      m_ovf  = 0;
    end else begin
      if (c) m_ovf = 1;
      if (if1.load) begin
        m_cnt = (int'(if1.load_val) >= int'(MOD)) ? int'(MOD) - 1 : int'(if1.load_val);
      end else if (if1.stop) begin
        m_busy = 0;
      end else if (if1.start && !m_busy) begin
        m_busy = 1;
        m_done = 0;
      end else if (m_busy && if1.en) begin
        m_cnt = if1.up_dn ? (m_cnt + 1) % int'(MOD) : (m_cnt + int'(MOD) - 1) % int'(MOD);
        if (if1.one_shot && c) begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic idle_inputs();
    if1.en       = 1'b0;
    if1.start    = 1'b0;
    if1.stop     = 1'b0;
    if1.clear    = 1'b0;
    if1.load     = 1'b0;
    if1.load_val = '0;
    if1.up_dn    = 1'b1;
    if1.one_shot = 1'b0;
    if2.start    = 1'b0;
    if2.stop     = 1'b0;
    if2.clear    = 1'b0;
    if2.load     = 1'b0;
    if2.load_val = '0;
    if2.up_dn    = 1'b1;
    if2.one_shot = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    chk("reset.count", 32'(if1.count), 0);
    chk("reset.busy", 32'(if1.busy), 0);
    chk("reset.done", 32'(if1.done), 0);
    chk("reset.carry", 32'(if1.carry), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Free-run up: 0,1..9,0
    if1.en    = 1'b1;
    if1.start = 1'b1;
    step("fr_start");
    if1.start = 1'b0;
    for (int i = 0; i < 10; i++) step("fr_up");
    chk("fr_wrap.count", 32'(if1.count), 0);
    chk("fr_wrap.busy", 32'(if1.busy), 1);
    for (int i = 0; i < 4; i++) step("fr_up2");

    // Asynchronous reset away from any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset.count", 32'(if1.count), 0);
    chk("mid_reset.busy", 32'(if1.busy), 0);
    chk("mid_reset.carry", 32'(if1.carry), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One-shot down from 3: 3,2,1,0,9 then DONE
    if1.load     = 1'b1;
    if1.load_val = 4'd3;
    step("os_load");
    if1.load     = 1'b0;
    if1.start    = 1'b1;
    if1.up_dn    = 1'b0;
    if1.one_shot = 1'b1;
    step("os_start");
    if1.start = 1'b0;
    for (int i = 0; i < 4; i++) step("os_down");
    chk("os_end.count", 32'(if1.count), 9);
    chk("os_end.done", 32'(if1.done), 1);
    chk("os_end.busy", 32'(if1.busy), 0);
    step("os_hold");

    // en gating from 9 counting up
    if1.one_shot = 1'b0;
    if1.up_dn    = 1'b1;
    if1.start    = 1'b1;
    step("eg_start");
    if1.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if1.en = (i % 2 == 0);
      step("eg");
    end
    chk("eg_end.count", 32'(if1.count), 2);

    // Priority cases
    if1.en    = 1'b1;
    if1.clear = 1'b1;
    if1.load  = 1'b1;
    if1.stop  = 1'b1;
    if1.load_val = 4'd5;
    step("pri_clear");
    chk("pri_clear.count", 32'(if1.count), 0);
    if1.clear = 1'b0;
    if1.stop  = 1'b0;
    if1.load_val = 4'd12;
    step("pri_clamp");
    chk("pri_clamp.count", 32'(if1.count), 9);
    if1.load  = 1'b0;
    if1.start = 1'b1;
    step("pri_run");
    if1.stop = 1'b1;
    step("pri_stopstart");
    chk("pri_stopstart.busy", 32'(if1.busy), 0);
    if1.stop  = 1'b0;
    if1.start = 1'b0;

    // Random stimulus vs model
    for (int i = 0; i < 400; i++) begin
      if1.clear    = ($urandom_range(0, 19) == 0);
      if1.load     = ($urandom_range(0, 9) == 0);
      if1.stop     = ($urandom_range(0, 11) == 0);
      if1.start    = ($urandom_range(0, 3) == 0);
      if1.en       = ($urandom_range(0, 3) != 0);
      if1.up_dn    = ($urandom_range(0, 7) != 0) ? if1.up_dn : ~if1.up_dn;
      if1.one_shot = ($urandom_range(0, 15) != 0) ? if1.one_shot : ~if1.one_shot;
      if1.load_val = W'($urandom_range(0, 15));
      step("rnd");
    end

    // Cascade: stage2 counts stage1 wraps
    idle_inputs();
    if1.clear = 1'b1;
    if2.clear = 1'b1;
    step("cas_clear");
    if1.clear = 1'b0;
    if2.clear = 1'b0;
    if1.start = 1'b1;
    if2.start = 1'b1;
    if1.en    = 1'b1;
    step("cas_start");
    if1.start = 1'b0;
    if2.start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step("cas");
      chk("cas.c2", 32'(if2.count), (k / 10) % 10);
      chk("cas.c1", 32'(if1.count), k % 10);
`ifdef MOD_COUNTER_OVF_STICKY_EN
      chk("cas.ovf1", 32'(if1.ovf), 32'(k >= 10));
`endif
    end
    chk("cas_end.pair", {24'd0, if2.count, if1.count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
